// File: rtl/ahb_lcd_wr_port.sv
// AHB-Lite write port feeding an 8080-style LCD bus through a small FIFO.
// Bus writes to DATA/CMD stall on a full FIFO; a back-end FSM strobes entries out.
module ahb_lcd_wr_port #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        LCD_CSn,
  output logic        LCD_DC,
  output logic        LCD_WRn,
  output logic        LCD_RSTn,
  output logic [15:0] LCD_D
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } lcd_state_t;

  localparam logic [FIFO_AW:0]   FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};

  function automatic logic [15:0] lane_extract(input logic [31:0] wdata,
                                               input logic [2:0]  size,
                                               input logic [1:0]  offs);
    logic [15:0] r;
    case (size)
      3'd0: begin
        case (offs)
          2'd0:    r = {8'h00, wdata[7:0]};
          2'd1:    r = {8'h00, wdata[15:8]};
          2'd2:    r = {8'h00, wdata[23:16]};
          default: r = {8'h00, wdata[31:24]};
        endcase
      end
      3'd1:    r = offs[1] ? wdata[31:16] : wdata[15:0];
      default: r = wdata[15:0];
    endcase
    return r;
  endfunction

  logic              dp_active_r, dp_write_r;
  logic [2:0]        dp_size_r;
  logic [3:0]        dp_addr_r;
  logic [8:0]        ctrl_r;
  logic [31:0]       hrdata_r;
  logic [16:0]       fifo_mem_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]  level_r;
  lcd_state_t        state_r;
  logic [3:0]        cnt_r;
  logic              csn_r, wrn_r, dc_r;
  logic [15:0]       d_r;

  logic              accept_s, fifo_wr_s, empty_s, full_s, push_s, pop_s;
  logic [31:0]       status_s, rdata_s;
  logic              unused_s;

  assign accept_s  = HSEL & HREADY & HTRANS[1];
  assign fifo_wr_s = dp_active_r & dp_write_r & ~dp_addr_r[3];
  assign empty_s   = (level_r == {(FIFO_AW+1){1'b0}});
  assign full_s    = (level_r == FULL_LEVEL);
  assign push_s    = fifo_wr_s & ~full_s;
  // The FSM consumes the head in IDLE or at the last HOLD cycle
  assign pop_s     = ~empty_s & ((state_r == ST_IDLE) |
                                 ((state_r == ST_HOLD) & (cnt_r == 4'd0)));
  assign unused_s  = ^{HADDR[31:4], HTRANS[0]};

  assign HREADYOUT = ~(fifo_wr_s & full_s);
  assign HRESP     = 1'b0;
  assign HRDATA    = hrdata_r;
  assign LCD_CSn   = csn_r;
  assign LCD_WRn   = wrn_r;
  assign LCD_DC    = dc_r;
  assign LCD_D     = d_r;
  assign LCD_RSTn  = ctrl_r[8];

  // Read mux for the register selected in the address phase
  always_comb begin
    status_s              = 32'h0000_0000;
    status_s[FIFO_AW:0]   = level_r;
    status_s[16]          = empty_s;
    status_s[17]          = full_s;
    status_s[18]          = (state_r != ST_IDLE) | ~empty_s;
    case (HADDR[3:2])
      2'd2:    rdata_s = status_s;
      2'd3:    rdata_s = {23'h000000, ctrl_r};
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // AHB address/data-phase pipeline, read data and CTRL register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_active_r <= 1'b0;
      dp_write_r  <= 1'b0;
      dp_size_r   <= 3'd0;
      dp_addr_r   <= 4'd0;
      hrdata_r    <= 32'h0000_0000;
      ctrl_r      <= 9'h000;
    end else begin
      if (HREADY) begin
        dp_active_r <= accept_s;
        dp_write_r  <= HWRITE;
        dp_size_r   <= HSIZE;
        dp_addr_r   <= HADDR[3:0];
        hrdata_r    <= (accept_s & ~HWRITE) ? rdata_s : 32'h0000_0000;
      end
      if (dp_active_r & dp_write_r & (dp_addr_r[3:2] == 2'd3)) begin
        ctrl_r <= HWDATA[8:0];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      level_r  <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (push_s & ~pop_s)      level_r <= level_r + LVL_ONE;
      else if (pop_s & ~push_s) level_r <= level_r - LVL_ONE;
    end
  end

  // FIFO storage; DATA (offset 0) carries dc=1, CMD (offset 4) dc=0
  always_ff @(posedge HCLK) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {~dp_addr_r[2], lane_extract(HWDATA, dp_size_r, dp_addr_r[1:0])};
    end
  end

  // LCD write-cycle sequencer with registered bus outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      csn_r   <= 1'b1;
      wrn_r   <= 1'b1;
      dc_r    <= 1'b1;
      d_r     <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wrn_r <= 1'b1;
          if (pop_s) begin
            {dc_r, d_r} <= fifo_mem_r[rd_ptr_r];
            csn_r       <= 1'b0;
            state_r     <= ST_SETUP;
          end else begin
            csn_r <= 1'b1;
          end
        end
        ST_SETUP: begin
          wrn_r   <= 1'b0;
          cnt_r   <= ctrl_r[3:0];
          state_r <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt_r == 4'd0) begin
            wrn_r   <= 1'b1;
            cnt_r   <= ctrl_r[7:4];
            state_r <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (pop_s) begin
            {dc_r, d_r} <= fifo_mem_r[rd_ptr_r];
            state_r     <= ST_SETUP;
          end else begin
            csn_r   <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          csn_r   <= 1'b1;
          wrn_r   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lcd_wr_port.sv
// Scoreboard bench for ahb_lcd_wr_port: expected LCD words are queued as writes
// are issued and compared as each strobe starts; strobe widths are measured too.
module tb_ahb_lcd_wr_port;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        LCD_CSn, LCD_DC, LCD_WRn, LCD_RSTn;
  logic [15:0] LCD_D;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_lcd_wr_port #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .LCD_CSn(LCD_CSn), .LCD_DC(LCD_DC), .LCD_WRn(LCD_WRn), .LCD_RSTn(LCD_RSTn),
    .LCD_D(LCD_D)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] sb_q[$];
  int          exp_low = 1;
  int          exp_high = 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // LCD monitor: compare each word at strobe start, measure low/high widths
  logic        prev_wrn = 1'b1;
  logic        in_word = 1'b0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  logic [31:0] exp_w;
  logic [31:0] cur_word;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      prev_wrn = 1'b1;
      in_word  = 1'b0;
      low_cnt  = 0;
      high_cnt = 0;
    end else begin
      if (prev_wrn && !LCD_WRn) begin
        if (in_word) check_eq("wr_high_b2b", high_cnt, exp_high + 1);
        if (sb_q.size() != 0) exp_w = {15'd0, sb_q.pop_front()};
        else exp_w = 32'hDEAD_0000;
        cur_word = {15'd0, LCD_DC, LCD_D};
        check_eq("lcd_word", cur_word, exp_w);
        check_eq("csn_in_strobe", 32'(LCD_CSn), 32'd0);
        low_cnt = 1;
        in_word = 1'b1;
      end else if (!prev_wrn && LCD_WRn) begin
        check_eq("wr_low", low_cnt, exp_low);
        check_eq("word_stable", {15'd0, LCD_DC, LCD_D}, cur_word);
        high_cnt = 1;
      end else if (!LCD_WRn) begin
        low_cnt++;
      end else if (in_word && !LCD_CSn) begin
        high_cnt++;
      end else if (in_word && LCD_CSn) begin
        check_eq("wr_high_end", high_cnt, exp_high);
        in_word = 1'b0;
      end
      prev_wrn = LCD_WRn;
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int waits);
    int g;
    logic done;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    waits = 0; g = 0; done = 1'b0; rdata = 32'h0;
    while (!done && g < 3000) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        rdata = HRDATA;
        done = 1'b1;
      end else begin
        waits++;
      end
      g++;
    end
    check_eq("xfer_done", 32'(done), 32'd1);
    @(posedge HCLK); #1;
  endtask

  task automatic burst_write(input logic [31:0] addr, input int n, input logic [31:0] first,
                             output int stalls);
    int i;
    int g;
    logic rdy;
    i = 0; g = 0; stalls = 0;
    while (i <= n && g < 5000) begin
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b1; HSIZE = 3'd2;
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      if (i > 0) HWDATA = first + 32'(i - 1);
      @(negedge HCLK);
      rdy = HREADYOUT;
      @(posedge HCLK); #1;
      if (rdy) i++;
      else stalls++;
      g++;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    check_eq("burst_done", i, n + 1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || !LCD_CSn) && g < 3000) begin
      @(negedge HCLK);
      g++;
    end
    @(negedge HCLK);
    check_eq("drain_q", sb_q.size(), 32'd0);
    check_eq("drain_csn", 32'(LCD_CSn), 32'd1);
    @(posedge HCLK); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int w;
    int st;
    int g;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HSIZE = 3'd0; HWRITE = 1'b0;
    HWDATA = 32'h0; HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    check_eq("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check_eq("rst_hresp", 32'(HRESP), 32'd0);
    check_eq("rst_hrdata", HRDATA, 32'h0);
    check_eq("rst_csn", 32'(LCD_CSn), 32'd1);
    check_eq("rst_wrn", 32'(LCD_WRn), 32'd1);
    check_eq("rst_dc", 32'(LCD_DC), 32'd1);
    check_eq("rst_d", 32'(LCD_D), 32'd0);
    check_eq("rst_lcd_rstn", 32'(LCD_RSTn), 32'd0);
    @(posedge HCLK); #1;
    xfer(1'b0, 32'h8, 3'd2, 32'h0, rd, w);
    check_eq("rst_status", rd, 32'h0001_0000);
    xfer(1'b0, 32'hC, 3'd2, 32'h0, rd, w);
    check_eq("rst_ctrl", rd, 32'h0);

    // Strobe timing WR_LOW=2, WR_HIGH=1 and lane extraction
    xfer(1'b1, 32'hC, 3'd2, 32'h0000_0112, rd, w);
    exp_low = 3; exp_high = 2;
    check_eq("lcd_rstn_set", 32'(LCD_RSTn), 32'd1);
    xfer(1'b0, 32'hC, 3'd2, 32'h0, rd, w);
    check_eq("ctrl_rb", rd, 32'h0000_0112);
    sb_q.push_back(17'h1_BEEF);
    xfer(1'b1, 32'h0, 3'd1, 32'h0000_BEEF, rd, w);
    wait_drain();
    sb_q.push_back(17'h0_00AB);
    xfer(1'b1, 32'h6, 3'd0, 32'h00AB_0000, rd, w);
    wait_drain();
    sb_q.push_back(17'h1_1234);
    xfer(1'b1, 32'h2, 3'd1, 32'h1234_5678, rd, w);
    wait_drain();
    sb_q.push_back(17'h1_005A);
    xfer(1'b1, 32'h1, 3'd0, 32'h0000_5A00, rd, w);
    wait_drain();
    sb_q.push_back(17'h0_CAFE);
    xfer(1'b1, 32'h4, 3'd2, 32'h7777_CAFE, rd, w);
    wait_drain();
    xfer(1'b1, 32'h8, 3'd2, 32'hFFFF_FFFF, rd, w);
    xfer(1'b0, 32'h8, 3'd2, 32'h0, rd, w);
    check_eq("status_ro", rd, 32'h0001_0000);

    // Slow strobes so 20 back-to-back writes overrun the 16-entry FIFO
    xfer(1'b1, 32'hC, 3'd2, 32'h0000_00FF, rd, w);
    exp_low = 16; exp_high = 16;
    for (int k = 0; k < 20; k++) sb_q.push_back({1'b1, 16'(k)});
    burst_write(32'h0, 20, 32'h0, st);
    check_eq("burst_stalled", 32'(st != 0), 32'd1);
    wait_drain();
    xfer(1'b0, 32'h8, 3'd2, 32'h0, rd, w);
    check_eq("burst_status", rd, 32'h0001_0000);

    // Six writes: one in flight on the LCD bus, five left queued
    for (int k = 0; k < 6; k++) sb_q.push_back({1'b1, 16'(256 + k)});
    burst_write(32'h0, 6, 32'h100, st);
    xfer(1'b0, 32'h8, 3'd2, 32'h0, rd, w);
    check_eq("status_lvl5", rd, 32'h0004_0005);
    check_eq("status_waits", w, 32'd0);
    wait_drain();

    // Reset while the first of four words is strobing
    for (int k = 0; k < 4; k++) sb_q.push_back({1'b1, 16'(512 + k)});
    burst_write(32'h0, 4, 32'h200, st);
    g = 0;
    while (LCD_WRn && g < 200) begin
      @(negedge HCLK);
      g++;
    end
    check_eq("strobe_seen", 32'(LCD_WRn), 32'd0);
    @(posedge HCLK);
    check_eq("queued_at_rst", sb_q.size(), 32'd3);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("arst_wrn", 32'(LCD_WRn), 32'd1);
    check_eq("arst_csn", 32'(LCD_CSn), 32'd1);
    check_eq("arst_dc_d", {15'd0, LCD_DC, LCD_D}, 32'h0001_0000);
    check_eq("arst_hreadyout", 32'(HREADYOUT), 32'd1);
    sb_q.delete();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(1'b0, 32'h8, 3'd2, 32'h0, rd, w);
    check_eq("post_rst_status", rd, 32'h0001_0000);
    xfer(1'b0, 32'hC, 3'd2, 32'h0, rd, w);
    check_eq("post_rst_ctrl", rd, 32'h0);
    check_eq("post_rst_lcd_rstn", 32'(LCD_RSTn), 32'd0);
    repeat (60) @(posedge HCLK);
    #1;
    check_eq("post_rst_idle_csn", 32'(LCD_CSn), 32'd1);
    check_eq("sb_left", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
